ask_demod_ctrl: RTL and testbench
=================================

Name: ask_demod_ctrl

Overview:
Acquisition and bit-timing controller that sits after the ASK envelope rectifier/low-pass filter.
- Sequences start-up: waits out the filter flush, then estimates an adaptive slicing threshold from the 14-bit envelope.
- Recovers symbol timing from envelope transitions and emits one hard bit per symbol.
- Declares and drops lock, re-acquiring on its own without software involvement.

Parameters:
DW, 14, envelope sample width (signed).
SPS, 16, valid samples per symbol; even, >= 4.
SETTLE, 64, valid samples discarded after enable (filter flush).
EST_SYMS, 32, symbols in the threshold estimation window.
MIN_SWING, 256, minimum max-min envelope swing required to accept an estimate.
LOSS_SYMS, 16, consecutive transition-free symbols that declare loss of lock.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
enable  in  1  level; 1 = run, 0 = force IDLE
env_in  in  DW  signed filtered envelope sample
env_valid  in  1  env_in qualifier; all counters advance only when 1
bit_out  out  1  recovered bit (1 = carrier present)
bit_valid  out  1  one-cycle strobe qualifying bit_out
locked  out  1  1 while in TRACK
threshold  out  DW  signed slicing threshold currently in use
state  out  2  0 IDLE, 1 SETTLE, 2 ESTIMATE, 3 TRACK

Behaviour:
Reset
- rst is asynchronous, active-high.
- Reset values: state=IDLE, bit_out=0, bit_valid=0, locked=0, threshold=0; all counters, max and min registers cleared.

IDLE
- Entered from any state on the cycle after enable is sampled 0; that same edge clears bit_valid and locked.
- threshold holds its last value.
- Leaves for SETTLE on the first clk edge with enable=1; the sample counter clears on entry.

SETTLE
- Counts valid samples only.
- After SETTLE valid samples, goes to ESTIMATE.

ESTIMATE
- On entry: max = most negative value, min = most positive value, counter = 0.
- For each valid sample, update the signed running max and min.
- After EST_SYMS*SPS valid samples, check the swing, computed with a DW+1-bit signed subtract:
  - swing >= MIN_SWING: threshold <= (max+min)>>>1, using a DW+1-bit signed sum and arithmetic shift that rounds toward -inf. Go to TRACK with locked=1.
  - otherwise: restart ESTIMATE (clear max, min and counter); threshold unchanged.

TRACK
- Slice each valid sample: s = (env_in > threshold), strict compare. Register s_prev.
- Phase counter ph runs 0..SPS-1, incrementing on each valid sample and wrapping SPS-1 -> 0.
- Transition (s != s_prev) on a valid sample loads ph <= 1, so the transition sample is phase 0. The transition load takes priority over wrap.
- Decision: when a valid sample arrives with ph == SPS/2, the next edge gives bit_out <= s and a one-cycle bit_valid pulse (latency 1 clk from that sample).
- A transition on the decision sample resyncs the phase and suppresses that decision.
- s_prev is initialised to the first TRACK sample's slice, so no false transition occurs on entry.

Loss of lock
- Symbol counter increments on each ph wrap and clears on any transition.
- Reaching LOSS_SYMS: locked <= 0, go to ESTIMATE; bit_valid is not asserted on that edge.

Other rules
- env_valid=0 freezes every counter and register except the state change forced by enable=0.
- Mid-operation enable drop then re-raise always restarts from SETTLE.
- rst asserted mid-operation returns all outputs to reset values immediately.

Test Plan:
1. Reset, then enable=1 with env_valid always 1 -> state goes 1 for 64 cycles, then 2 for 512 cycles, then 3.
2. Envelope alternating 2000/200 every 16 samples (bit pattern 1010...) -> threshold=1100, locked=1; one bit_valid per 16 cycles, bit_out alternates, strobe 1 clk after phase-8 sample.
3. Constant envelope 500 (swing 0 < 256) -> state stays 2, ESTIMATE restarts every 512 samples, locked=0, no bit_valid.
4. Locked on pattern from 2, then envelope held at 2000 for 16 symbols -> locked falls after the 16th transition-free symbol; state=2; bit_out=1 strobes until then.
5. In TRACK, env_valid toggled 1/0 each cycle -> bit_valid period doubles to 32 cycles with the same bit sequence; negative-min case with max=-100, min=-901 -> threshold=-501.
6. enable dropped for 1 cycle mid-TRACK -> state=0 next edge, locked=0, restart through SETTLE; rst pulse mid-ESTIMATE -> all outputs 0 immediately.

Source files
------------

// File: rtl/ask_demod_ctrl.sv
// ASK demodulator acquisition/bit-timing controller: filter flush, adaptive threshold
// estimation, transition-driven symbol timing and autonomous lock/re-acquire.
module ask_demod_ctrl #(
   parameter int unsigned DW        = 14,
   parameter int unsigned SPS       = 16,
   parameter int unsigned SETTLE    = 64,
   parameter int unsigned EST_SYMS  = 32,
   parameter int unsigned MIN_SWING = 256,
   parameter int unsigned LOSS_SYMS = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic signed [DW-1:0] env_in,
   input  logic                 env_valid,
   output logic                 bit_out,
   output logic                 bit_valid,
   output logic                 locked,
   output logic signed [DW-1:0] threshold,
   output logic [1:0]           state
);

   localparam int unsigned EstLen = EST_SYMS * SPS;
   localparam int unsigned CntMax = (EstLen > SETTLE) ? EstLen : SETTLE;
   localparam int unsigned CW     = $clog2(CntMax + 1);
   localparam int unsigned PW     = $clog2(SPS);
   localparam int unsigned LW     = $clog2(LOSS_SYMS + 1);

   localparam logic signed [DW-1:0] EnvMax   = {1'b0, {(DW-1){1'b1}}};
   localparam logic signed [DW-1:0] EnvMin   = {1'b1, {(DW-1){1'b0}}};
   localparam logic signed [DW:0]   MinSwing = (DW+1)'(MIN_SWING);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StSettle = 2'd1,
      StEst    = 2'd2,
      StTrack  = 2'd3
   } state_e;

   state_e                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic signed [DW-1:0]  max_q, max_d, min_q, min_d, thr_q, thr_d;
   logic [PW-1:0]         ph_q, ph_d;
   logic [LW-1:0]         sym_q, sym_d;
   logic                  s_prev_q, s_prev_d, first_q, first_d;
   logic                  bit_out_q, bit_out_d, bit_valid_q, bit_valid_d, locked_q, locked_d;

   logic signed [DW-1:0]  max_upd, min_upd;
   logic signed [DW:0]    max_x, min_x, swing, sum;
   logic                  slice, trans;

   always_comb begin
      max_upd = (env_in > max_q) ? env_in : max_q;
      min_upd = (env_in < min_q) ? env_in : min_q;
      max_x   = max_upd;
      min_x   = min_upd;
      swing   = max_x - min_x;
      sum     = max_x + min_x;
      slice   = env_in > thr_q;
      // First TRACK sample seeds s_prev, so it can never be a transition.
      trans   = !first_q && (slice != s_prev_q);
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      max_d       = max_q;
      min_d       = min_q;
      thr_d       = thr_q;
      ph_d        = ph_q;
      sym_d       = sym_q;
      s_prev_d    = s_prev_q;
      first_d     = first_q;
      bit_out_d   = bit_out_q;
      bit_valid_d = 1'b0;
      locked_d    = locked_q;

      if (!enable) begin
         state_d  = StIdle;
         locked_d = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               state_d = StSettle;
               cnt_d   = '0;
            end
            StSettle: if (env_valid) begin
               if (cnt_q == CW'(SETTLE - 1)) begin
                  state_d = StEst;
                  cnt_d   = '0;
                  max_d   = EnvMin;
                  min_d   = EnvMax;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            StEst: if (env_valid) begin
               max_d = max_upd;
               min_d = min_upd;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(EstLen - 1)) begin
                  cnt_d = '0;
                  if (swing >= MinSwing) begin
                     thr_d    = DW'(sum >>> 1);
                     state_d  = StTrack;
                     locked_d = 1'b1;
                     first_d  = 1'b1;
                     ph_d     = '0;
                     sym_d    = '0;
                  end else begin
                     max_d = EnvMin;
                     min_d = EnvMax;
                  end
               end
            end
            StTrack: if (env_valid) begin
               first_d  = 1'b0;
               s_prev_d = slice;
               if (trans) begin
                  ph_d  = PW'(1);
                  sym_d = '0;
               end else if (ph_q == PW'(SPS - 1)) begin
                  ph_d = '0;
                  if (sym_q == LW'(LOSS_SYMS - 1)) begin
                     locked_d = 1'b0;
                     state_d  = StEst;
                     cnt_d    = '0;
                     sym_d    = '0;
                     max_d    = EnvMin;
                     min_d    = EnvMax;
                  end else begin
                     sym_d = sym_q + 1'b1;
                  end
               end else begin
                  ph_d = ph_q + 1'b1;
               end
               if (ph_q == PW'(SPS / 2) && !trans) begin
                  bit_out_d   = slice;
                  bit_valid_d = 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         max_q       <= '0;
         min_q       <= '0;
         thr_q       <= '0;
         ph_q        <= '0;
         sym_q       <= '0;
         s_prev_q    <= 1'b0;
         first_q     <= 1'b0;
         bit_out_q   <= 1'b0;
         bit_valid_q <= 1'b0;
         locked_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         max_q       <= max_d;
         min_q       <= min_d;
         thr_q       <= thr_d;
         ph_q        <= ph_d;
         sym_q       <= sym_d;
         s_prev_q    <= s_prev_d;
         first_q     <= first_d;
         bit_out_q   <= bit_out_d;
         bit_valid_q <= bit_valid_d;
         locked_q    <= locked_d;
      end
   end

   assign bit_out   = bit_out_q;
   assign bit_valid = bit_valid_q;
   assign locked    = locked_q;
   assign threshold = thr_q;
   assign state     = state_q;

endmodule

// File: tb/tb_ask_demod_ctrl.sv
// Directed bench for ask_demod_ctrl: acquisition sequence, bit timing, loss of lock,
// env_valid gating, negative threshold, enable drop and asynchronous reset.
module tb_ask_demod_ctrl;

   logic               clk = 1'b0;
   logic               rst;
   logic               enable;
   logic signed [13:0] env_in;
   logic               env_valid;
   logic               bit_out, bit_valid, locked;
   logic signed [13:0] threshold;
   logic [1:0]         state;

   int tests = 0;
   int fails = 0;

   ask_demod_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .env_in    (env_in),
      .env_valid (env_valid),
      .bit_out   (bit_out),
      .bit_valid (bit_valid),
      .locked    (locked),
      .threshold (threshold),
      .state     (state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int pos_pat(input int k);
      return (((k >> 4) & 1) == 0) ? 2000 : 200;
   endfunction

   function automatic int neg_pat(input int k);
      return (((k >> 4) & 1) == 0) ? -100 : -901;
   endfunction

   // Sample index k of the TRACK decision points for the 16-aligned patterns below.
   function automatic bit is_dec(input int k);
      return (k == 585) || (k >= 600 && (k % 16) == 8);
   endfunction

   initial begin
      rst       = 1'b1;
      enable    = 1'b0;
      env_valid = 1'b0;
      env_in    = '0;
      #1;
      check("rst_state", state, 0);
      check("rst_bit_out", bit_out, 0);
      check("rst_bit_valid", bit_valid, 0);
      check("rst_locked", locked, 0);
      check("rst_threshold", threshold, 0);
      @(posedge clk); #1;
      rst       = 1'b0;
      enable    = 1'b1;
      env_valid = 1'b1;

      // Valid every cycle: lock on 2000/200, hold 2000 until loss, then constant 500.
      for (int k = 0; k < 1984; k++) begin
         if (k < 704)      env_in = 14'(pos_pat(k));
         else if (k < 960) env_in = 14'sd2000;
         else              env_in = 14'sd500;
         @(posedge clk); #1;
         if (k == 0 || k == 63) check("settle_state", state, 1);
         if (k == 64 || k == 575) check("est_state", state, 2);
         if (k == 575) check("est_unlocked", locked, 0);
         if (k == 576) begin
            check("track_state", state, 3);
            check("track_locked", locked, 1);
            check("threshold_pos", threshold, 1100);
         end
         if (k >= 577 && k <= 959) begin
            check("bit_valid", bit_valid, is_dec(k));
            if (is_dec(k))
               check("bit_out", bit_out, (k < 704) ? ((pos_pat(k) == 2000) ? 1 : 0) : 1);
         end
         if (k == 958) begin
            check("pre_loss_locked", locked, 1);
            check("pre_loss_state", state, 3);
         end
         if (k == 959) begin
            check("loss_locked", locked, 0);
            check("loss_state", state, 2);
         end
         if (k >= 960) check("no_strobe_flat", bit_valid, 0);
         if (k == 1471 || k == 1983) begin
            check("flat_state", state, 2);
            check("flat_threshold", threshold, 1100);
            check("flat_locked", locked, 0);
         end
      end

      // Asynchronous reset mid-ESTIMATE.
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_state", state, 0);
      check("async_rst_bit_out", bit_out, 0);
      check("async_rst_locked", locked, 0);
      check("async_rst_threshold", threshold, 0);
      enable = 1'b0;
      @(posedge clk); #1;
      rst    = 1'b0;
      enable = 1'b1;

      // env_valid on even cycles only; negative envelope, garbage on idle cycles.
      for (int c = 0; c <= 1440; c++) begin
         env_valid = ((c % 2) == 0);
         env_in    = env_valid ? 14'(neg_pat(c / 2)) : 14'sd5000;
         @(posedge clk); #1;
         if (c == 127) check("half_settle_state", state, 1);
         if (c == 128 || c == 1151) check("half_est_state", state, 2);
         if (c == 1152) begin
            check("half_track_state", state, 3);
            check("half_locked", locked, 1);
            check("threshold_neg", threshold, -501);
         end
         if (c >= 1154) begin
            check("half_bit_valid", bit_valid, env_valid && is_dec(c / 2));
            if (env_valid && is_dec(c / 2))
               check("half_bit_out", bit_out, (neg_pat(c / 2) == -100) ? 1 : 0);
         end
      end

      // One-cycle enable drop from TRACK, then restart through SETTLE.
      env_valid = 1'b1;
      env_in    = 14'sd0;
      enable    = 1'b0;
      @(posedge clk); #1;
      check("drop_state", state, 0);
      check("drop_locked", locked, 0);
      check("drop_bit_valid", bit_valid, 0);
      check("drop_threshold_hold", threshold, -501);
      enable = 1'b1;
      for (int k = 0; k <= 64; k++) begin
         @(posedge clk); #1;
         if (k == 0 || k == 63) check("restart_settle", state, 1);
         if (k == 64) check("restart_est", state, 2);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
